divider_arbiter: RTL and testbench

//   Shares one sequential divider instance between N_REQ requesters (e.g. hours/minutes/seconds

---
 rtl/divider_arbiter.sv | 130 +++++++++++++
 tb/tb_divider_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one sequential divider between N_REQ requesters.
// Sequences the divider Start/Done/Ack handshake and routes results back.
module divider_arbiter #(
  parameter int N_REQ = 3,
  parameter int DW    = 7,
  parameter int QW    = 5
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_x,
  input  logic [N_REQ*DW-1:0] req_y,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [QW-1:0]       rsp_q,
  output logic [QW-1:0]       rsp_r,
  output logic                rsp_err,
  output logic                busy,
  output logic [DW-1:0]       div_x,
  output logic [DW-1:0]       div_y,
  output logic                div_start,
  output logic                div_ack,
  input  logic                div_done,
  input  logic [QW-1:0]       div_q,
  input  logic [QW-1:0]       div_r
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, START, WAIT, ACK, ZERO
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, win, id, ptr_nxt, idx;
  logic            found;
  logic [DW-1:0]   win_x, win_y;

  // scan from rr_ptr upward, wrapping, first requester wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_x   = req_x[win*DW +: DW];
  assign win_y   = req_y[win*DW +: DW];
  assign ptr_nxt = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (found)
          state_nxt = (win_y == '0) ? ZERO : START;
      end
      START: state_nxt = WAIT;
      WAIT:  if (div_done) state_nxt = ACK;
      ACK:   if (!div_done) state_nxt = IDLE;
      ZERO:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      id        <= '0;
      gnt       <= '0;
      done      <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_err   <= 1'b0;
      div_x     <= '0;
      div_y     <= '0;
      div_start <= 1'b0;
      div_ack   <= 1'b0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt[win]  <= 1'b1;
            div_x     <= win_x;
            div_y     <= win_y;
            id        <= win;
            rr_ptr    <= ptr_nxt;
            div_start <= (win_y != '0);
          end
        end
        WAIT: begin
          if (div_done) begin
            rsp_q    <= div_q;
            rsp_r    <= div_r;
            rsp_err  <= 1'b0;
            done[id] <= 1'b1;
            div_ack  <= 1'b1;
          end
        end
        ACK: begin
          if (!div_done) div_ack <= 1'b0;
        end
        // divide-by-zero answered locally, divider never started
        ZERO: begin
          done[id] <= 1'b1;
          rsp_q    <= '1;
          rsp_r    <= div_x[QW-1:0];
          rsp_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural divider model.
// Table of single-requester vectors plus multi-cycle sequences.
module tb_divider_arbiter;

  localparam int N   = 3;
  localparam int DW  = 7;
  localparam int QW  = 5;
  localparam int LAT = 3;

  logic            sys_clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_x = '0;
  logic [N*DW-1:0] req_y = '0;
  logic [N-1:0]    gnt, done;
  logic [QW-1:0]   rsp_q, rsp_r;
  logic            rsp_err, busy;
  logic [DW-1:0]   div_x, div_y;
  logic            div_start, div_ack;
  logic            div_done;
  logic [QW-1:0]   div_q, div_r;

  int total = 0;
  int bad = 0;
  int nstart = 0;
  int hold = 0;
  int cnt, hcnt;

  divider_arbiter #(.N_REQ(N), .DW(DW), .QW(QW)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req(req), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .done(done),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .busy(busy),
    .div_x(div_x), .div_y(div_y),
    .div_start(div_start), .div_ack(div_ack),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 sys_clk = ~sys_clk;

  // divider: Done LAT edges after Start, dropped hold edges after Ack seen
  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_done <= 1'b0;
      div_q    <= '0;
      div_r    <= '0;
      cnt      <= 0;
      hcnt     <= 0;
    end else if (div_start) begin
      cnt <= LAT;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        div_done <= 1'b1;
        div_q    <= QW'(div_x / div_y);
        div_r    <= QW'(div_x % div_y);
        hcnt     <= 0;
      end
    end else if (div_done && div_ack) begin
      if (hcnt == hold) div_done <= 1'b0;
      else              hcnt <= hcnt + 1;
    end
  end

  always @(posedge sys_clk)
    if (!rst && div_start) nstart <= nstart + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge sys_clk);
      cyc++;
      if (gnt != '0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) who = i;
        check("gnt_onehot", 64'($onehot(gnt)), 1);
        break;
      end
    end
    if (who < 0) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge sys_clk);
      cyc++;
      if (done != '0) begin
        for (int i = 0; i < N; i++) if (done[i]) who = i;
        check("done_onehot", 64'($onehot(done)), 1);
        break;
      end
    end
    if (who < 0) check("done_timeout", 0, 1);
  endtask

  task automatic set_op(input int i, input int x, input int y);
    req_x[i*DW +: DW] = DW'(x);
    req_y[i*DW +: DW] = DW'(y);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int id;
    int x;
    int y;
    int q;
    int r;
    int err;
    int lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int who, cyc, n0, acks;
    bit gnt_seen, idle_seen;
    int exp_q[3];
    int exp_r[3];
    int ord[4];

    vecs[0] = '{0,  59, 10,  5,  9, 0, 5};
    vecs[1] = '{1,  23,  0, 31, 23, 1, 1};
    vecs[2] = '{2, 127,  5, 25,  2, 0, 5};
    vecs[3] = '{1,   7,  9,  0,  7, 0, 5};
    vecs[4] = '{0, 100,  0, 31,  4, 1, 1};
    vecs[5] = '{2,  31,  1, 31,  0, 0, 5};

    #1;
    check("reset_outs",
          64'({gnt, done, rsp_q, rsp_r, rsp_err, busy,
               div_x, div_y, div_start, div_ack}), 0);
    do_reset();

    foreach (vecs[k]) begin
      n0 = nstart;
      set_op(vecs[k].id, vecs[k].x, vecs[k].y);
      req[vecs[k].id] = 1'b1;
      wait_gnt(who, cyc);
      check("gnt_id", who, vecs[k].id);
      check("start_at_gnt", div_start, vecs[k].y != 0);
      check("busy_at_gnt", busy, 1);
      req[vecs[k].id] = 1'b0;
      wait_done(who, cyc);
      check("done_id", who, vecs[k].id);
      check("done_lat", cyc, vecs[k].lat);
      check("rsp_q", rsp_q, vecs[k].q);
      check("rsp_r", rsp_r, vecs[k].r);
      check("rsp_err", rsp_err, vecs[k].err);
      @(negedge sys_clk);
      check("done_pulse", done, 0);
      check("rsp_q_hold", rsp_q, vecs[k].q);
      check("start_cycles", nstart - n0, vecs[k].y != 0);
    end

    // three simultaneous requests from a fresh pointer
    do_reset();
    exp_q = '{0, 3, 4};
    exp_r = '{4, 4, 0};
    set_op(0, 4, 10);
    set_op(1, 34, 10);
    set_op(2, 40, 10);
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(who, cyc);
      check("rr3_gnt", who, k);
      if (who >= 0) req[who] = 1'b0;
      wait_done(who, cyc);
      check("rr3_done", who, k);
      check("rr3_q", rsp_q, exp_q[k]);
      check("rr3_r", rsp_r, exp_r[k]);
    end

    // pointer at 1, requesters 0 and 2 held
    repeat (4) @(negedge sys_clk);
    set_op(0, 9, 3);
    req[0] = 1'b1;
    wait_gnt(who, cyc);
    check("pre_gnt", who, 0);
    req[0] = 1'b0;
    wait_done(who, cyc);
    set_op(2, 9, 3);
    repeat (3) @(negedge sys_clk);
    ord = '{2, 0, 2, 0};
    req = 3'b101;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(who, cyc);
      check("alt_gnt", who, ord[k]);
      if (k == 3) req = '0;
      wait_done(who, cyc);
      check("alt_done", who, ord[k]);
      check("alt_q", rsp_q, 3);
    end

    // reset while the divider is working
    repeat (4) @(negedge sys_clk);
    set_op(1, 50, 7);
    req[1] = 1'b1;
    wait_gnt(who, cyc);
    req[1] = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("in_wait_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outs",
          64'({gnt, done, rsp_q, rsp_r, rsp_err, busy,
               div_x, div_y, div_start, div_ack}), 0);
    @(negedge sys_clk);
    rst = 1'b0;
    gnt_seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge sys_clk);
      if (done != '0 || busy) gnt_seen = 1'b1;
    end
    check("no_done_after_rst", gnt_seen, 0);
    set_op(2, 50, 7);
    req[2] = 1'b1;
    wait_gnt(who, cyc);
    check("post_rst_gnt", who, 2);
    req[2] = 1'b0;
    wait_done(who, cyc);
    check("post_rst_q", rsp_q, 7);
    check("post_rst_r", rsp_r, 1);

    // divider keeps Done high three extra cycles after Ack
    repeat (4) @(negedge sys_clk);
    hold = 3;
    set_op(0, 20, 6);
    set_op(1, 17, 4);
    req[0] = 1'b1;
    wait_gnt(who, cyc);
    req[0] = 1'b0;
    wait_done(who, cyc);
    check("hold_q", rsp_q, 3);
    check("hold_r", rsp_r, 2);
    req[1] = 1'b1;
    acks = 0;
    gnt_seen = 1'b0;
    idle_seen = 1'b0;
    for (int n = 0; n < 20 && div_ack; n++) begin
      acks++;
      if (gnt != '0) gnt_seen = 1'b1;
      if (!busy) idle_seen = 1'b1;
      @(negedge sys_clk);
    end
    check("ack_cycles", acks, 5);
    check("no_gnt_in_ack", gnt_seen, 0);
    check("busy_in_ack", idle_seen, 0);
    wait_gnt(who, cyc);
    check("after_ack_gnt", who, 1);
    req[1] = 1'b0;
    wait_done(who, cyc);
    check("after_ack_q", rsp_q, 4);
    check("after_ack_r", rsp_r, 1);
    hold = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
